// File: rtl/codec_smpl_src.sv
// codec_smpl_src: serial audio receiver for the sample circular buffers.
// It generates the codec clocks from a free-running 10-bit divider and
// deserializes left-justified, MSB-first stereo frames from SDin. It
// presents one left/right word pair per 1024-clk frame and raises a
// one-cycle valid strobe with each pair.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   SDin        serial data from codec ADC (synchronous to SCLK)
//   MCLK        codec master clock  (cnt[1])
//   SCLK        serial bit clock    (cnt[4])
//   LRCLK       channel select      (cnt[9]; 0 = left, 1 = right)
//   codec_rst_n codec reset, rst_n delayed by one clk
//   lft_smpl    last complete left word
//   rght_smpl   last complete right word
//   smpl_vld    one-cycle strobe; lft_smpl/rght_smpl hold a new frame
module codec_smpl_src #(
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SDin,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        codec_rst_n,
  output logic [15:0] lft_smpl,
  output logic [15:0] rght_smpl,
  output logic        smpl_vld
);

  localparam logic [3:0] SKIP = 4'(SKIP_FRAMES);

  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] lft_shadow_q, lft_shadow_d;
  logic [15:0] lft_q, lft_d;
  logic [15:0] rght_q, rght_d;
  logic        vld_q, vld_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        codec_rst_q;
  logic        frame_done;

  always_comb begin
    cnt_d        = cnt_q + 10'd1;
    shift_d      = shift_q;
    lft_shadow_d = lft_shadow_q;
    lft_d        = lft_q;
    rght_d       = rght_q;
    vld_d        = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_done   = (cnt_q == 10'd1008);

    // Capture on the edge at which SCLK rises.
    if (cnt_q[4:0] == 5'd15) begin
      shift_d = {shift_q[14:0], SDin};
    end

    // Left word is complete after the last capture of the first half.
    if (cnt_q == 10'd496) begin
      lft_shadow_d = shift_q;
    end

    // Both registers update every frame; only the strobe is gated
    // by the settle count.
    if (frame_done) begin
      lft_d  = lft_shadow_q;
      rght_d = shift_q;
      vld_d  = (frame_cnt_q == SKIP);
      if (frame_cnt_q != SKIP) begin
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    codec_rst_q <= rst_n;
    if (!rst_n) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      lft_shadow_q <= '0;
      lft_q        <= '0;
      rght_q       <= '0;
      vld_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      lft_shadow_q <= lft_shadow_d;
      lft_q        <= lft_d;
      rght_q       <= rght_d;
      vld_q        <= vld_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign MCLK        = cnt_q[1];
  assign SCLK        = cnt_q[4];
  assign LRCLK       = cnt_q[9];
  assign codec_rst_n = codec_rst_q;
  assign lft_smpl    = lft_q;
  assign rght_smpl   = rght_q;
  assign smpl_vld    = vld_q;

endmodule

// File: doc/codec_smpl_src.md
Name: codec_smpl_src

Overview:
- Serial audio receiver that produces the 16-bit samples and the one-cycle write strobe consumed by the sample circular buffers.
- Generates the codec bit clocks (MCLK, SCLK, LRCLK) from the system clock with a free-running divider.
- Deserializes left-justified, MSB-first stereo frames from SDin and presents one left and one right word per frame, with a one-cycle valid strobe.
- Sits between the codec pins and the left/right buffers: lft_smpl/rght_smpl drive new_smpl, and smpl_vld drives wrt_smpl.

Parameters:
- SKIP_FRAMES, 2, number of complete frames after reset whose data is discarded (smpl_vld suppressed) while the codec settles; legal range 0..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- SDin  input  1  serial data from codec ADC
- MCLK  output  1  codec master clock, cnt[1]
- SCLK  output  1  serial bit clock, cnt[4]
- LRCLK  output  1  channel select, cnt[9]; 0 = left, 1 = right
- codec_rst_n  output  1  codec reset, rst_n delayed one clk
- lft_smpl  output  16  last complete left word
- rght_smpl  output  16  last complete right word
- smpl_vld  output  1  one-cycle strobe; lft_smpl/rght_smpl hold a new frame

Behaviour:
- Reset: synchronous, active-low, sampled on posedge clk.
  - While rst_n=0 at an edge, the following clear to 0: cnt, shift_reg, lft_shadow, lft_smpl, rght_smpl, smpl_vld, frame_cnt, codec_rst_n.
  - MCLK, SCLK and LRCLK therefore read 0.
  - Reset mid-frame discards the partial frame and restarts the SKIP_FRAMES count; no smpl_vld is produced for the partial data.
- Divider: 10-bit cnt, +1 every clk, wraps 1023->0.
  - MCLK period 4 clk; SCLK period 32 clk; LRCLK period 1024 clk.
  - 16 SCLK periods per LRCLK half.
- Bit capture: on the edge where cnt[4:0]==5'd15 (the edge at which SCLK rises), shift_reg <= {shift_reg[14:0], SDin}.
  - 16 captures per half, at cnt[8:0] = 15, 47, ..., 495.
  - The first captured bit is the MSB.
- Left latch: on the edge where cnt==496, lft_shadow <= shift_reg.
- Frame complete: on the edge where cnt==1008, the following update together:
  - lft_smpl <= lft_shadow
  - rght_smpl <= shift_reg
  - frame_cnt <= frame_cnt+1, saturating at SKIP_FRAMES
  - smpl_vld <= 1 if frame_cnt==SKIP_FRAMES before the increment, else 0
- smpl_vld is cleared on the next edge, so it is exactly 1 clk wide, once per 1024 clk.
- lft_smpl and rght_smpl are stable from one frame-complete edge to the next. Skipped frames still update both registers; only the strobe is suppressed.
- SKIP_FRAMES=0: the first frame-complete edge after reset asserts smpl_vld.
- Latency: the right-channel LSB is captured at cnt==1007 and is visible on rght_smpl at cnt==1009, with smpl_vld=1 in that same cycle.
- codec_rst_n <= rst_n each edge, so it rises one clk after reset release.
- SDin is treated as synchronous to the generated SCLK; no metastability flops are included (codec clocked by our SCLK).

Test Plan:
- Reset: hold rst_n=0 for 5 clk, then release.
  - All outputs read 0 during reset.
  - codec_rst_n rises 1 clk after release.
  - SCLK first rises 16 clk after release; LRCLK first rises 512 clk after release.
- Clock ratios: run 4096 clk.
  - MCLK has 1024 rising edges, SCLK 128, LRCLK 4.
  - Each LRCLK half contains exactly 16 SCLK rises.
- Data path: model drives left=16'hA5C3 and right=16'h1234, MSB first, changing SDin on SCLK falling edges. With SKIP_FRAMES=2:
  - First smpl_vld occurs in the 3rd frame at cnt==1009.
  - At that strobe, lft_smpl=16'hA5C3 and rght_smpl=16'h1234.
- Strobe width: over 10 frames with SKIP_FRAMES=0, smpl_vld pulses 10 times, each 1 clk wide, spaced exactly 1024 clk apart.
- Pattern change: left=16'h8000 then 16'h0001, right=16'hFFFF then 16'h0000 on successive frames.
  - Outputs update only at the frame-complete edge.
  - Values are held unchanged between strobes.
- Mid-frame reset: assert rst_n=0 at cnt==700 for 1 clk.
  - cnt restarts at 0 and outputs clear.
  - No smpl_vld appears for the next SKIP_FRAMES frames.
